pll_lock_supervisor: RTL and testbench

Lock supervisor and reset sequencer on the consuming side of the core PLL. It drives the PLL's active-high reset and watches its asynchronous `locked` output. It holds the downstream system in reset until lock is stable, and re-arms the PLL on lock loss, lock timeout or software request. It runs on the PLL reference clock, so it stays live while the PLL output clocks are absent.

---
 rtl/pll_sup_pkg.sv | 26 ++
 rtl/pll_lock_supervisor_sync_bit.sv | 24 ++
 rtl/pll_lock_supervisor.sv | 110 +++++++++++
 tb/tb_pll_lock_supervisor.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/pll_sup_pkg.sv
// pll_sup_pkg: shared types and constants for the PLL lock supervisor.
//   sup_state_t : supervisor FSM states
//   COUNT_W     : width of the saturating event counters
//   max4()      : largest of four values, used to size the shared cycle counter
package pll_sup_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } sup_state_t;

  localparam int unsigned COUNT_W = 8;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync_bit.sv
// sync_bit: N-stage flop synchronizer for a single asynchronous bit.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears every stage to 0
//   d     : asynchronous input
//   q     : synchronized output (last stage)
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: PLL reset sequencer and lock supervisor, clocked by the
// PLL reference clock.
//   refclk      : reference clock (single clock of the block)
//   rst_n       : asynchronous active-low reset
//   locked_in   : PLL lock indication, asynchronous to refclk
//   relock_req  : one-cycle request to force a full PLL re-lock
//   pll_rst     : active-high reset to the PLL
//   sys_rst_n   : active-low reset to downstream logic, released only in RUN
//   lock_ok     : high only in RUN
//   retry_count : saturating count of lock timeouts
//   loss_count  : saturating count of lock losses seen in RUN
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned SYNC_STAGES         = 2,
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536
) (
  input  logic               refclk,
  input  logic               rst_n,
  input  logic               locked_in,
  input  logic               relock_req,
  output logic               pll_rst,
  output logic               sys_rst_n,
  output logic               lock_ok,
  output logic [COUNT_W-1:0] retry_count,
  output logic [COUNT_W-1:0] loss_count
);

  localparam int unsigned CNT_MAX = max4(SYNC_STAGES, PLL_RST_CYCLES,
                                         LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

  sup_state_t       state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             cnt_clr;
  logic             retry_inc, loss_inc;
  logic             lock_s;

  sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (locked_in),
    .q     (lock_s)
  );

  always_comb begin
    state_nx  = state;
    retry_inc = 1'b0;
    loss_inc  = 1'b0;
    if (relock_req) begin
      state_nx = PLL_RST;
    end else begin
      case (state)
        PLL_RST:   if (cnt == RST_LAST) state_nx = WAIT_LOCK;
        WAIT_LOCK: begin
          if (lock_s) begin
            state_nx = STABLE;
          end else if (cnt == TIMEOUT_LAST) begin
            state_nx  = PLL_RST;
            retry_inc = 1'b1;
          end
        end
        STABLE: begin
          if (!lock_s)                 state_nx = WAIT_LOCK;
          else if (cnt == STABLE_LAST) state_nx = RUN;
        end
        RUN: begin
          if (!lock_s) begin
            state_nx = PLL_RST;
            loss_inc = 1'b1;
          end
        end
        default: state_nx = PLL_RST;
      endcase
    end
  end

  // A relock request while already in PLL_RST still restarts the pulse, so it
  // clears the counter like any other transition.
  assign cnt_clr = relock_req || (state_nx != state);

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= PLL_RST;
      cnt         <= '0;
      pll_rst     <= 1'b1;
      sys_rst_n   <= 1'b0;
      lock_ok     <= 1'b0;
      retry_count <= '0;
      loss_count  <= '0;
    end else begin
      state <= state_nx;
      // Counter holds at all-ones instead of wrapping (only reachable in RUN).
      if (cnt_clr)   cnt <= '0;
      else if (~&cnt) cnt <= cnt + 1'b1;
      pll_rst   <= (state_nx == PLL_RST);
      sys_rst_n <= (state_nx == RUN);
      lock_ok   <= (state_nx == RUN);
      if (retry_inc && (~&retry_count)) retry_count <= retry_count + 1'b1;
      if (loss_inc  && (~&loss_count))  loss_count  <= loss_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: directed test of the PLL lock supervisor with
// SYNC_STAGES=2, PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32.
// Edge 0 is the refclk edge just before rst_n is released; all samples are
// taken 1 time unit after a rising edge.
module tb_pll_lock_supervisor;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       locked_in;
  logic       relock_req;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       lock_ok;
  logic [7:0] retry_count;
  logic [7:0] loss_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 refclk = ~refclk;

  pll_lock_supervisor #(
    .SYNC_STAGES         (2),
    .PLL_RST_CYCLES      (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (32)
  ) dut (
    .refclk      (refclk),
    .rst_n       (rst_n),
    .locked_in   (locked_in),
    .relock_req  (relock_req),
    .pll_rst     (pll_rst),
    .sys_rst_n   (sys_rst_n),
    .lock_ok     (lock_ok),
    .retry_count (retry_count),
    .loss_count  (loss_count)
  );

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @edge %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge refclk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic check_outs(input string tag, input int prst, input int srst,
                            input int lok, input int rc, input int lc);
    check({tag, ".pll_rst"},     pll_rst,     prst);
    check({tag, ".sys_rst_n"},   sys_rst_n,   srst);
    check({tag, ".lock_ok"},     lock_ok,     lok);
    check({tag, ".retry_count"}, retry_count, rc);
    check({tag, ".loss_count"},  loss_count,  lc);
  endtask

  int w;
  int t;

  initial begin
    rst_n      = 1'b0;
    locked_in  = 1'b0;
    relock_req = 1'b0;
    repeat (3) step();
    check_outs("reset", 1, 0, 0, 0, 0);

    // Release after edge 0.
    cyc   = 0;
    rst_n = 1'b1;

    // Power-up pulse and lock-to-release.
    for (int k = 1; k <= 3; k++) begin
      run_to(k);
      check("pup.pll_rst_hi", pll_rst, 1);
    end
    run_to(4);   check("pup.pll_rst_lo", pll_rst, 0);
    run_to(9);   locked_in = 1'b1;              // sampled at edge 10
    run_to(19);  check_outs("pup.pre", 0, 0, 0, 0, 0);
    run_to(20);  check_outs("pup.run", 0, 1, 1, 0, 0);

    // Lock loss in RUN: locked_in low sampled at edge 22.
    run_to(21);  locked_in = 1'b0;
    run_to(23);  check("loss.pre.sys_rst_n", sys_rst_n, 1);
    run_to(24);  check_outs("loss", 1, 0, 0, 0, 1);
    locked_in = 1'b1;                           // re-lock, sampled at 25
    run_to(27);  check("loss.pll_rst_hi", pll_rst, 1);
    run_to(28);  check("loss.pll_rst_lo", pll_rst, 0);
    run_to(36);  check("relock.pre.sys_rst_n", sys_rst_n, 0);
    run_to(37);  check_outs("relock.run", 0, 1, 1, 0, 1);

    // relock_req in RUN, sampled at edge 39.
    run_to(38);  relock_req = 1'b1;
    run_to(39);  relock_req = 1'b0;
    check_outs("rq_run", 1, 0, 0, 0, 1);
    run_to(42);  check("rq_run.pll_rst_hi", pll_rst, 1);
    run_to(43);  check("rq_run.pll_rst_lo", pll_rst, 0);
    // STABLE entered at 44; glitch low for edges 49..51 (stable count 5).
    run_to(48);  locked_in = 1'b0;
    run_to(51);  locked_in = 1'b1;
    run_to(52);  check("glitch.no_early_release", sys_rst_n, 0);
    run_to(55);  check_outs("glitch.wait", 0, 0, 0, 0, 1);
    run_to(61);  check("glitch.pre.sys_rst_n", sys_rst_n, 0);
    run_to(62);  check_outs("glitch.run", 0, 1, 1, 0, 1);

    // Lock lost for good; relock_req during WAIT_LOCK.
    locked_in = 1'b0;                           // sampled at 63
    run_to(65);  check_outs("loss2", 1, 0, 0, 0, 2);
    run_to(69);  check("loss2.wait.pll_rst", pll_rst, 0);
    run_to(74);  relock_req = 1'b1;
    run_to(75);  relock_req = 1'b0;
    check_outs("rq_wait", 1, 0, 0, 0, 2);
    run_to(78);  check("rq_wait.pll_rst_hi", pll_rst, 1);
    run_to(79);  check("rq_wait.pll_rst_lo", pll_rst, 0);

    // Timeouts: WAIT_LOCK entered at 79, retries every 36 edges from 111.
    run_to(110); check_outs("to.pre", 0, 0, 0, 0, 2);
    run_to(111); check_outs("to1", 1, 0, 0, 1, 2);
    run_to(114); check("to1.pll_rst_hi", pll_rst, 1);
    run_to(115); check("to1.pll_rst_lo", pll_rst, 0);
    run_to(146); check("to2.pre", retry_count, 1);
    run_to(147); check("to2", retry_count, 2);
    check("to2.pll_rst", pll_rst, 1);
    run_to(183); check("to3", retry_count, 3);
    w = 111 + 36 * 253;
    run_to(w);      check("to254", retry_count, 254);
    run_to(w + 36); check("to255", retry_count, 255);
    run_to(w + 72); check("to_sat", retry_count, 255);
    check("to_sat.pll_rst", pll_rst, 1);
    check("to_sat.loss", loss_count, 2);

    // Re-lock into STABLE, then async reset between edges.
    t = cyc;
    locked_in = 1'b1;
    run_to(t + 4);  check("ar.wait.pll_rst", pll_rst, 0);
    run_to(t + 8);  check_outs("ar.stable", 0, 0, 0, 255, 2);
    #3;
    rst_n = 1'b0;
    #1;
    check_outs("async_rst", 1, 0, 0, 0, 0);
    step();
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
